// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR packet buffer.
// FSM states are one-hot; stored words are {sop, eop, data}.
package fir_pkg;

    typedef enum logic [2:0] {
        W_IDLE  = 3'b001,
        W_STORE = 3'b010,
        W_DROP  = 3'b100
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'b01,
        R_SEND = 2'b10
    } rd_state_t;

    // Flag positions above the data field of a stored word
    localparam int SOP_BIT = 1;
    localparam int EOP_BIT = 0;

endpackage

// File: rtl/fir_pkt_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// The read register holds its value while rd_en is low.
module fir_pkt_ram #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fir_pkt_buffer.sv
// Store-and-forward packet FIFO behind the FIR stage: absorbs every input word,
// forwards only complete packets and drops whole packets that do not fit.
module fir_pkt_buffer
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 64,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  sink_ready,
    input  logic                  sink_valid,
    input  logic                  sink_startofpacket,
    input  logic                  sink_endofpacket,
    input  logic [DATA_WIDTH-1:0] sink_data,
    input  logic                  source_ready,
    output logic                  source_valid,
    output logic                  source_startofpacket,
    output logic                  source_endofpacket,
    output logic [DATA_WIDTH-1:0] source_data,
    output logic                  pkt_avail,
    output logic                  drop_pulse,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic [CNT_WIDTH-1:0]  abort_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int WW = DATA_WIDTH + 2;
    localparam logic [PW-1:0]        DEPTH_P = PW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    wr_state_t            wr_state_reg, wr_state_next;
    rd_state_t            rd_state_reg, rd_state_next;
    logic [PW-1:0]        wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]        commit_ptr_reg, commit_ptr_next;
    logic [PW-1:0]        rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]        pkt_cnt_reg, pkt_cnt_next;
    logic [CNT_WIDTH-1:0] drop_count_reg, drop_count_next;
    logic [CNT_WIDTH-1:0] abort_count_reg, abort_count_next;
    logic                 drop_pulse_reg;
    logic                 sink_ready_reg;

    logic                 accept, full, base_full, start_pkt;
    logic                 commit, drop, abort, rd_done;
    logic                 ram_we, ram_rd_en;
    logic [AW-1:0]        ram_waddr;
    logic [WW-1:0]        ram_q;
    logic                 q_eop;

    assign accept    = sink_valid & sink_ready_reg;
    assign full      = (wr_ptr_reg - rd_ptr_reg) == DEPTH_P;
    assign base_full = (commit_ptr_reg - rd_ptr_reg) == DEPTH_P;
    assign q_eop     = ram_q[DATA_WIDTH + EOP_BIT];

    // Write side: wr_ptr runs ahead speculatively, commit_ptr marks packet start
    always_comb begin
        wr_state_next   = wr_state_reg;
        wr_ptr_next     = wr_ptr_reg;
        commit_ptr_next = commit_ptr_reg;
        ram_we          = 1'b0;
        ram_waddr       = wr_ptr_reg[AW-1:0];
        start_pkt       = 1'b0;
        commit          = 1'b0;
        drop            = 1'b0;
        abort           = 1'b0;
        case (wr_state_reg)
            W_IDLE: begin
                if (accept && sink_startofpacket)
                    start_pkt = 1'b1;
            end
            W_STORE: begin
                if (accept) begin
                    if (sink_startofpacket) begin
                        abort     = 1'b1;
                        start_pkt = 1'b1;
                    end else if (full) begin
                        drop          = 1'b1;
                        wr_ptr_next   = commit_ptr_reg;
                        wr_state_next = sink_endofpacket ? W_IDLE : W_DROP;
                    end else begin
                        ram_we      = 1'b1;
                        wr_ptr_next = wr_ptr_reg + 1'b1;
                        if (sink_endofpacket) begin
                            commit          = 1'b1;
                            commit_ptr_next = wr_ptr_reg + 1'b1;
                            wr_state_next   = W_IDLE;
                        end
                    end
                end
            end
            W_DROP: begin
                if (accept && sink_startofpacket)
                    start_pkt = 1'b1;
                else if (accept && sink_endofpacket)
                    wr_state_next = W_IDLE;
            end
            default: wr_state_next = W_IDLE;
        endcase

        // A new packet always begins at commit_ptr, discarding any unfinished one
        if (start_pkt) begin
            ram_waddr = commit_ptr_reg[AW-1:0];
            if (base_full) begin
                drop          = 1'b1;
                wr_ptr_next   = commit_ptr_reg;
                wr_state_next = sink_endofpacket ? W_IDLE : W_DROP;
            end else begin
                ram_we      = 1'b1;
                wr_ptr_next = commit_ptr_reg + 1'b1;
                if (sink_endofpacket) begin
                    commit          = 1'b1;
                    commit_ptr_next = commit_ptr_reg + 1'b1;
                    wr_state_next   = W_IDLE;
                end else begin
                    wr_state_next = W_STORE;
                end
            end
        end
    end

    // Read side: RAM read register is the output register, fetched one word ahead
    always_comb begin
        rd_state_next = rd_state_reg;
        rd_ptr_next   = rd_ptr_reg;
        ram_rd_en     = 1'b0;
        rd_done       = 1'b0;
        case (rd_state_reg)
            R_IDLE: begin
                if (pkt_cnt_reg != '0) begin
                    ram_rd_en     = 1'b1;
                    rd_ptr_next   = rd_ptr_reg + 1'b1;
                    rd_state_next = R_SEND;
                end
            end
            R_SEND: begin
                if (source_ready) begin
                    rd_done = q_eop;
                    // Continue into the next packet only if it was committed before
                    // this cycle, so its first word is already in RAM.
                    if (!q_eop || pkt_cnt_reg > PW'(1)) begin
                        ram_rd_en   = 1'b1;
                        rd_ptr_next = rd_ptr_reg + 1'b1;
                    end else begin
                        rd_state_next = R_IDLE;
                    end
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        pkt_cnt_next     = pkt_cnt_reg;
        drop_count_next  = drop_count_reg;
        abort_count_next = abort_count_reg;
        if (commit && !rd_done)
            pkt_cnt_next = pkt_cnt_reg + 1'b1;
        else if (!commit && rd_done)
            pkt_cnt_next = pkt_cnt_reg - 1'b1;
        if (drop && drop_count_reg != CNT_MAX)
            drop_count_next = drop_count_reg + 1'b1;
        if (abort && abort_count_reg != CNT_MAX)
            abort_count_next = abort_count_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state_reg    <= W_IDLE;
            rd_state_reg    <= R_IDLE;
            wr_ptr_reg      <= '0;
            commit_ptr_reg  <= '0;
            rd_ptr_reg      <= '0;
            pkt_cnt_reg     <= '0;
            drop_count_reg  <= '0;
            abort_count_reg <= '0;
            drop_pulse_reg  <= 1'b0;
            sink_ready_reg  <= 1'b0;
        end else begin
            wr_state_reg    <= wr_state_next;
            rd_state_reg    <= rd_state_next;
            wr_ptr_reg      <= wr_ptr_next;
            commit_ptr_reg  <= commit_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            pkt_cnt_reg     <= pkt_cnt_next;
            drop_count_reg  <= drop_count_next;
            abort_count_reg <= abort_count_next;
            drop_pulse_reg  <= drop;
            sink_ready_reg  <= 1'b1;
        end
    end

    fir_pkt_ram #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data ({sink_startofpacket, sink_endofpacket, sink_data}),
        .rd_en   (ram_rd_en),
        .rd_addr (rd_ptr_reg[AW-1:0]),
        .rd_data (ram_q)
    );

    // The read register is not reset, so gate it with valid to keep outputs 0
    assign source_valid         = (rd_state_reg == R_SEND);
    assign source_startofpacket = source_valid & ram_q[DATA_WIDTH + SOP_BIT];
    assign source_endofpacket   = source_valid & q_eop;
    assign source_data          = source_valid ? ram_q[DATA_WIDTH-1:0] : '0;
    assign pkt_avail            = (pkt_cnt_reg != '0) | (rd_state_reg == R_SEND);
    assign drop_pulse           = drop_pulse_reg;
    assign drop_count           = drop_count_reg;
    assign abort_count          = abort_count_reg;
    assign sink_ready           = sink_ready_reg;

endmodule

// File: tb/tb_fir_pkt_buffer.sv
// Self-checking bench for fir_pkt_buffer: directed packet scenarios plus a
// randomized run checked against a word-queue model of the expected output.
module tb_fir_pkt_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 64;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sink_ready;
    logic          sink_valid = 1'b0;
    logic          sink_startofpacket = 1'b0;
    logic          sink_endofpacket = 1'b0;
    logic [DW-1:0] sink_data = '0;
    logic          source_ready;
    logic          source_valid;
    logic          source_startofpacket;
    logic          source_endofpacket;
    logic [DW-1:0] source_data;
    logic          pkt_avail;
    logic          drop_pulse;
    logic [CW-1:0] drop_count;
    logic [CW-1:0] abort_count;

    fir_pkt_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .sink_ready           (sink_ready),
        .sink_valid           (sink_valid),
        .sink_startofpacket   (sink_startofpacket),
        .sink_endofpacket     (sink_endofpacket),
        .sink_data            (sink_data),
        .source_ready         (source_ready),
        .source_valid         (source_valid),
        .source_startofpacket (source_startofpacket),
        .source_endofpacket   (source_endofpacket),
        .source_data          (source_data),
        .pkt_avail            (pkt_avail),
        .drop_pulse           (drop_pulse),
        .drop_count           (drop_count),
        .abort_count          (abort_count)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_cyc = 0;
    int first_vld_cyc = -1;
    int first_xfer_cyc = -1;
    int last_xfer_cyc = -1;
    int xfer_cnt = 0;
    int pkts_out = 0;
    int drop_pulses = 0;
    bit rnd_ready = 1'b0;
    bit fix_ready = 1'b0;
    bit in_pkt = 1'b0;
    bit hold_vld = 1'b0;
    logic [DW+1:0] hold_word = '0;
    logic [DW+1:0] exp_q[$];   // expected output words {sop, eop, data}

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        source_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            source_ready = rnd_ready ? 1'($urandom_range(0, 1)) : fix_ready;
        end
    end

    // Output monitor, sampled on the falling edge
    initial forever begin
        logic [DW+1:0] w;
        logic [DW+1:0] e;
        @(negedge clk);
        if (!reset_n) begin
            check("reset_out", {sink_ready, source_valid, source_startofpacket, source_endofpacket,
                                source_data, pkt_avail, drop_pulse, drop_count, abort_count}, 64'd0);
            in_pkt   = 1'b0;
            hold_vld = 1'b0;
        end else begin
            w = {source_startofpacket, source_endofpacket, source_data};
            if (drop_pulse) drop_pulses++;
            if (hold_vld) check("hold_stable", {source_valid, w}, {1'b1, hold_word});
            if (in_pkt) check("valid_gap", source_valid, 1);
            if (source_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            hold_vld  = source_valid && !source_ready;
            hold_word = w;
            if (source_valid && source_ready) begin
                check("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_word", w, e);
                    $display("xfer cyc=%0d sop=%0b eop=%0b data=%04h exp=%05h", cyc, w[DW+1], w[DW], w[DW-1:0], e);
                end
                if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
                xfer_cnt++;
                in_pkt = !source_endofpacket;
                if (source_endofpacket) pkts_out++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic sop, input logic eop, input logic [DW-1:0] d, input bit emit);
        sink_valid         = 1'b1;
        sink_startofpacket = sop;
        sink_endofpacket   = eop;
        sink_data          = d;
        if (emit) exp_q.push_back({sop, eop, d});
        last_cyc = cyc;
        @(posedge clk);
        #1;
        sink_valid         = 1'b0;
        sink_startofpacket = 1'b0;
        sink_endofpacket   = 1'b0;
    endtask

    task automatic send_pkt(input logic [DW-1:0] base, input int len, input bit emit,
                            input bit term, input bit gaps);
        for (int i = 0; i < len; i++) begin
            send_word(i == 0, term && (i == len - 1), base + DW'(i), emit);
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
        end
    endtask

    task automatic apply_reset();
        #2 reset_n = 1'b0;
        exp_q.delete();
        sink_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("sink_ready_up", sink_ready, 1);
        xfer_cnt = 0; pkts_out = 0; drop_pulses = 0;
        first_vld_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
        idle(4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single 6-word packet, consumer always ready
        apply_reset();
        fix_ready = 1'b1;
        idle(2);
        send_pkt(16'h0101, 6, 1'b1, 1'b1, 1'b0);
        wait_drain(200);
        check("t1_latency", first_vld_cyc - last_cyc, 2);
        check("t1_words", xfer_cnt, 6);
        check("t1_drop_count", drop_count, 0);

        // Two back-to-back 5-word packets held by back-pressure
        apply_reset();
        fix_ready = 1'b0;
        idle(2);
        send_pkt(16'h0200, 5, 1'b1, 1'b1, 1'b0);
        send_pkt(16'h0300, 5, 1'b1, 1'b1, 1'b0);
        idle(20);
        check("t2_avail_held", pkt_avail, 1);
        check("t2_no_xfer", xfer_cnt, 0);
        fix_ready = 1'b1;
        wait_drain(200);
        check("t2_contiguous", last_xfer_cyc - first_xfer_cyc, 9);
        check("t2_avail_done", pkt_avail, 0);

        // 40-word packet fits, following 30-word packet overflows
        apply_reset();
        fix_ready = 1'b0;
        idle(2);
        send_pkt(16'h0400, 40, 1'b1, 1'b1, 1'b0);
        send_pkt(16'h0500, 30, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("t3_drop_count", drop_count, 1);
        check("t3_drop_pulses", drop_pulses, 1);
        fix_ready = 1'b1;
        wait_drain(300);
        check("t3_words", xfer_cnt, 40);

        // Packet longer than the buffer, then a short packet
        apply_reset();
        fix_ready = 1'b1;
        idle(2);
        send_pkt(16'h0600, 70, 1'b0, 1'b1, 1'b0);
        send_pkt(16'h0700, 3, 1'b1, 1'b1, 1'b0);
        wait_drain(200);
        check("t4_drop_count", drop_count, 1);
        check("t4_words", xfer_cnt, 3);

        // Unterminated packet aborted by the next SOP
        apply_reset();
        fix_ready = 1'b1;
        idle(2);
        send_pkt(16'h0800, 3, 1'b0, 1'b0, 1'b0);
        send_pkt(16'h0900, 3, 1'b1, 1'b1, 1'b0);
        wait_drain(200);
        check("t5_abort_count", abort_count, 1);
        check("t5_drop_count", drop_count, 0);
        check("t5_words", xfer_cnt, 3);

        // Random lengths and back-pressure, with one reset mid-packet
        apply_reset();
        rnd_ready = 1'b1;
        idle(2);
        for (int p = 0; p < 20; p++) begin
            int len;
            int n;
            logic [DW-1:0] base;
            len  = $urandom_range(1, 50);
            base = DW'((p + 64) << 8);
            if (p == 10) begin
                send_pkt(base, 8, 1'b0, 1'b0, 1'b0);
                apply_reset();
                idle(1);
                $display("reset applied mid-packet before packet %0d", p);
                continue;
            end
            // Only start a packet the buffer is certain to hold, so nothing drops
            n = 0;
            while (exp_q.size() + len > DEPTH && n < 3000) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("rand_space", exp_q.size() + len <= DEPTH, 1);
            $display("send pkt %0d len=%0d", p, len);
            send_pkt(base, len, 1'b1, 1'b1, 1'b1);
            idle($urandom_range(0, 3));
        end
        wait_drain(5000);
        check("rand_pkts", pkts_out, 9);
        check("rand_drop_count", drop_count, 0);
        check("rand_abort_count", abort_count, 0);
        check("rand_avail_done", pkt_avail, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
